day_month_counter: RTL and testbench

DAY_MONTH_COUNTER -- requirements
Module: day_month_counter

---
 rtl/date_pkg.sv | 10 +
 rtl/month_len.sv | 20 ++
 rtl/day_month_counter.sv | 75 +++++++
 tb/tb_day_month_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// date_pkg: shared month constants, screen/edit-cursor codes and pending-edit actions for the date stage
package date_pkg;
    localparam logic [3:0] JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
                           MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
                           SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12;
    localparam logic [1:0] SCREEN_DATE = 2'd1;
    localparam logic [2:0] POS_MON_HI = 3'd3, POS_MON_LO = 3'd2,
                           POS_DAY_HI = 3'd1, POS_DAY_LO = 3'd0;
    typedef enum logic [2:0] {NONE, DAY_INC, DAY_DEC, MON_INC, MON_DEC} action_t;
endpackage

// File: rtl/month_len.sv
// month_len: days in a month; Feb 29 only exists when LEAP_YEAR_EN is defined and leap is set
module month_len
    import date_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] max_day
);
    logic leap_en;
`ifdef LEAP_YEAR_EN
    assign leap_en = leap;
`else
    assign leap_en = leap & 1'b0;
`endif
    // Lookup: long months 31, February 28/29, the rest 30
    always_comb
        max_day = (month == JAN || month == MAR || month == MAY || month == JUL ||
                   month == AUG || month == OCT || month == DEC) ? 5'd31 :
                  (month == FEB) ? (leap_en ? 5'd29 : 5'd28) : 5'd30;
endmodule

// File: rtl/day_month_counter.sv
// day_month_counter: calendar day/month stage with run-mode advance and key edits (LEAP_YEAR_EN enables Feb 29)
module day_month_counter
    import date_pkg::*;
#(
    parameter int RESET_DAY   = 1,
    parameter int RESET_MONTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ClkDay,
    input  logic       ClkLeap,
    input  logic       KeyPlus,
    input  logic       KeyMinus,
    input  logic       EditMode,
    input  logic [2:0] EditPos,
    input  logic [1:0] screen,
    output logic [4:0] days,
    output logic [3:0] months,
    output logic       ClkYear
);
    action_t    pend, key_act;
    logic       idle, on_mon, on_day;
    logic [3:0] mon_inc, mon_dec, mon_sel;
    logic [4:0] max_day;

    // Month neighbours, key decode, and the month whose length governs this cycle's update
    always_comb begin
        idle    = KeyPlus && KeyMinus && !ClkDay;
        mon_inc = (months == DEC) ? JAN : months + 4'd1;
        mon_dec = (months == JAN) ? DEC : months - 4'd1;
        mon_sel = (idle && pend == MON_INC) ? mon_inc :
                  (idle && pend == MON_DEC) ? mon_dec : months;
        on_mon  = EditPos == POS_MON_HI || EditPos == POS_MON_LO;
        on_day  = EditPos == POS_DAY_HI || EditPos == POS_DAY_LO;
        key_act = (!EditMode || screen != SCREEN_DATE) ? NONE :
                  on_mon ? (!KeyPlus ? MON_INC : MON_DEC) :
                  on_day ? (!KeyPlus ? DAY_INC : DAY_DEC) : NONE;
    end

    month_len u_len (.month(mon_sel), .leap(ClkLeap), .max_day(max_day));

    // Date state: reset > day tick > key latch > idle apply/clamp; edits never raise ClkYear
    always_ff @(posedge clk) begin
        ClkYear <= 1'b0;
        if (reset) begin
            days   <= 5'(RESET_DAY);
            months <= 4'(RESET_MONTH);
            pend   <= NONE;
        end else if (ClkDay) begin
            pend <= NONE;
            if (!EditMode) begin
                if (days < max_day) begin
                    days <= days + 5'd1;
                end else begin
                    days    <= 5'd1;
                    months  <= mon_inc;
                    ClkYear <= months == DEC;
                end
            end
        end else if (!KeyPlus || !KeyMinus) begin
            pend <= key_act;
        end else begin
            pend <= NONE;
            case (pend)
                MON_INC, MON_DEC: begin
                    months <= mon_sel;
                    days   <= (days > max_day) ? max_day : days;
                end
                DAY_INC: days <= (days >= max_day) ? 5'd1 : days + 5'd1;
                DAY_DEC: days <= (days <= 5'd1 || days > max_day) ? max_day : days - 5'd1;
                default: days <= (days > max_day) ? max_day : days;
            endcase
        end
    end
endmodule

// File: tb/tb_day_month_counter.sv
// tb_day_month_counter: scoreboard bench for the day/month stage; leap expectations follow LEAP_YEAR_EN
module tb_day_month_counter;
    logic       clk = 0, reset = 0, ClkDay = 0, ClkLeap = 0, KeyPlus = 1, KeyMinus = 1, EditMode = 0;
    logic [2:0] EditPos = 0;
    logic [1:0] screen = 1;
    logic [4:0] days;
    logic [3:0] months;
    logic       ClkYear;
    int         checks = 0, failures = 0;

    typedef struct {
        string      name;
        logic [4:0] d;
        logic [3:0] m;
        logic       y;
    } exp_t;
    exp_t q[$];

    day_month_counter #(.RESET_DAY(1), .RESET_MONTH(1)) dut (
        .clk(clk), .reset(reset), .ClkDay(ClkDay), .ClkLeap(ClkLeap), .KeyPlus(KeyPlus),
        .KeyMinus(KeyMinus), .EditMode(EditMode), .EditPos(EditPos), .screen(screen),
        .days(days), .months(months), .ClkYear(ClkYear)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle, so compare one queued expectation per falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (days !== e.d || months !== e.m || ClkYear !== e.y) begin
                failures++;
                $display("FAIL %s: got %0d/%0d y=%b, want %0d/%0d y=%b",
                         e.name, days, months, ClkYear, e.d, e.m, e.y);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input int d, input int m, input bit y);
        q.push_back('{name, 5'(d), 4'(m), y});
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic day_tick();
        ClkDay = 1;
        tick();
        ClkDay = 0;
    endtask

    task automatic press(input bit plus, input logic [2:0] pos, input logic [1:0] scr);
        EditMode = 1;
        EditPos  = pos;
        screen   = scr;
        if (plus) KeyPlus = 0; else KeyMinus = 0;
        tick();
        KeyPlus  = 1;
        KeyMinus = 1;
        tick();
    endtask

    initial begin
        do_reset();
        expect_state("reset", 1, 1, 0);
        for (int i = 2; i <= 31; i++) begin
            day_tick();
            expect_state("jan_advance", i, 1, 0);
        end
        day_tick();
        expect_state("jan31_to_feb1", 1, 2, 0);

        do_reset();
        press(0, 3'd3, 2'd1);
        expect_state("mon_wrap_1_to_12", 1, 12, 0);
        press(0, 3'd0, 2'd1);
        expect_state("day_wrap_1_to_31", 31, 12, 0);
        EditMode = 0;
        day_tick();
        expect_state("dec31_year_pulse", 1, 1, 1);
        tick();
        expect_state("year_pulse_ends", 1, 1, 0);
        press(0, 3'd2, 2'd1);
        press(1, 3'd2, 2'd1);
        expect_state("edit_wrap_no_year", 1, 1, 0);

        do_reset();
        press(1, 3'd3, 2'd1);
        press(0, 3'd0, 2'd1);
        expect_state("preset_feb28", 28, 2, 0);
        EditMode = 0;
        ClkLeap  = 1;
        day_tick();
`ifdef LEAP_YEAR_EN
        expect_state("feb28_leap", 29, 2, 0);
        ClkLeap = 0;
        tick();
        expect_state("leap_drop_clamp", 28, 2, 0);
        ClkLeap = 1;
        day_tick();
        expect_state("feb29_again", 29, 2, 0);
        day_tick();
        expect_state("feb29_to_mar1", 1, 3, 0);
`else
        expect_state("feb28_leap_disabled", 1, 3, 0);
`endif
        ClkLeap = 0;
        do_reset();
        press(1, 3'd3, 2'd1);
        press(0, 3'd0, 2'd1);
        EditMode = 0;
        day_tick();
        expect_state("feb28_nonleap", 1, 3, 0);

        do_reset();
        press(0, 3'd0, 2'd1);
        expect_state("jan31_preset", 31, 1, 0);
        press(1, 3'd3, 2'd1);
        expect_state("month_inc_clamp", 28, 2, 0);
        press(0, 3'd0, 2'd1);
        expect_state("day_dec", 27, 2, 0);
        press(1, 3'd3, 2'd0);
        press(0, 3'd0, 2'd0);
        expect_state("other_screen", 27, 2, 0);
        press(1, 3'd5, 2'd1);
        expect_state("bad_editpos", 27, 2, 0);
        press(1, 3'd1, 2'd1);
        expect_state("day_inc", 28, 2, 0);
        press(1, 3'd1, 2'd1);
        expect_state("day_wrap_max_to_1", 1, 2, 0);

        KeyPlus = 0;
        EditPos = 3'd0;
        tick();
        ClkDay = 1;
        tick();
        ClkDay  = 0;
        KeyPlus = 1;
        tick();
        expect_state("clkday_discards_edit", 1, 2, 0);

        press(1, 3'd2, 2'd1);
        KeyPlus = 0;
        EditPos = 3'd3;
        tick();
        reset = 1;
        tick();
        reset   = 0;
        KeyPlus = 1;
        tick();
        expect_state("reset_during_hold", 1, 1, 0);

        tick();
        tick();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
